// File: rtl/seq_ctrl_switch.sv
// seq_ctrl_switch
//   Registered switch that routes one of NUM_SRC pulse-sequence controller
//   buses to the bridge/dump driver stage. A change of source never happens
//   mid-sequence. The switch first waits for the active source to go idle,
//   bounded by DRAIN_MAX cycles. It then drives SAFE_VAL for GUARD_CYC cycles,
//   and only after that hands over to the newly selected source.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sel          in   requested source index (values >= NUM_SRC are ignored)
//   src_ctrl     in   packed source buses, source i at [i*CTRL_W +: CTRL_W]
//   src_busy     in   source i is mid-sequence when bit i is 1
//   ctrl_out     out  registered control bus to the driver stage
//   active_sel   out  index currently routed
//   switching    out  high while draining or guarding
//   sw_done      out  one-cycle pulse in the handover cycle
//   timeout_err  out  one-cycle pulse when the drain wait expired
//
// Build option
//   SEQ_SW_SYNC_SEL_EN : when defined, sel and src_busy each pass through a
//   2-flop synchroniser before use. This supports sources in another clock
//   domain and adds 2 cycles to every sel/busy reaction.

module seq_ctrl_switch #(
  parameter int                NUM_SRC   = 2,
  parameter int                SEL_W     = 1,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] SAFE_VAL  = {CTRL_W{1'b0}},
  parameter int                GUARD_CYC = 4,
  parameter int                DRAIN_MAX = 1023
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*CTRL_W-1:0] src_ctrl,
  input  logic [NUM_SRC-1:0]        src_busy,
  output logic [CTRL_W-1:0]         ctrl_out,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      switching,
  output logic                      sw_done,
  output logic                      timeout_err
);

  localparam int               LP_NSLOT      = 1 << SEL_W;
  localparam logic [SEL_W:0]   LP_NUM        = (SEL_W+1)'(NUM_SRC);
  localparam logic [15:0]      LP_DRAIN_LAST = 16'(DRAIN_MAX - 1);
  localparam logic [7:0]       LP_GUARD_LAST = 8'(GUARD_CYC - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GUARD, S_SWITCH} state_t;

  logic [SEL_W-1:0]   w_sel;
  logic [NUM_SRC-1:0] w_busy;

`ifdef SEQ_SW_SYNC_SEL_EN
  logic [SEL_W-1:0]   r_sel_s1, r_sel_s2;
  logic [NUM_SRC-1:0] r_busy_s1, r_busy_s2;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_s1  <= '0;
      r_sel_s2  <= '0;
      r_busy_s1 <= '0;
      r_busy_s2 <= '0;
    end else begin
      r_sel_s1  <= sel;
      r_sel_s2  <= r_sel_s1;
      r_busy_s1 <= src_busy;
      r_busy_s2 <= r_busy_s1;
    end
  end

  assign w_sel  = r_sel_s2;
  assign w_busy = r_busy_s2;
`else
  assign w_sel  = sel;
  assign w_busy = src_busy;
`endif

  // Pad the source table to a full power of two so any SEL_W-bit index is
  // in range. Unused slots are never selected; they read as safe/idle.
  logic [CTRL_W-1:0]   w_src [LP_NSLOT];
  logic [LP_NSLOT-1:0] w_busy_slot;

  for (genvar gi = 0; gi < LP_NSLOT; gi++) begin : g_slot
    if (gi < NUM_SRC) begin : g_used
      assign w_src[gi]       = src_ctrl[gi*CTRL_W +: CTRL_W];
      assign w_busy_slot[gi] = w_busy[gi];
    end else begin : g_unused
      assign w_src[gi]       = SAFE_VAL;
      assign w_busy_slot[gi] = 1'b0;
    end
  end

  state_t            r_state, w_nxt_state;
  logic [SEL_W-1:0]  r_active, w_nxt_active;
  logic [SEL_W-1:0]  r_pending, w_nxt_pending;
  logic [15:0]       r_drain_cnt, w_nxt_drain_cnt;
  logic [7:0]        r_guard_cnt, w_nxt_guard_cnt;
  logic [CTRL_W-1:0] r_ctrl_out;
  logic              r_switching, r_sw_done, r_timeout_err;
  logic              w_sel_valid, w_req, w_timeout;
  logic [SEL_W-1:0]  w_sel_eff;

  // An out-of-range select behaves like "stay where you are".
  assign w_sel_valid = ({1'b0, w_sel} < LP_NUM);
  assign w_sel_eff   = w_sel_valid ? w_sel : r_active;
  assign w_req       = (w_sel_eff != r_active);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_active    = r_active;
    w_nxt_pending   = r_pending;
    w_nxt_drain_cnt = r_drain_cnt;
    w_nxt_guard_cnt = r_guard_cnt;
    w_timeout       = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_req) begin
          w_nxt_pending   = w_sel_eff;
          w_nxt_drain_cnt = '0;
          w_nxt_state     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_req) begin
          w_nxt_state = S_RUN;
        end else begin
          // Retarget keeps the drain count running.
          w_nxt_pending = w_sel_eff;
          // A busy-fall wins over a coincident timeout.
          if (!w_busy_slot[r_active]) begin
            w_nxt_guard_cnt = '0;
            w_nxt_state     = S_GUARD;
          end else if (r_drain_cnt == LP_DRAIN_LAST) begin
            w_timeout       = 1'b1;
            w_nxt_guard_cnt = '0;
            w_nxt_state     = S_GUARD;
          end else begin
            w_nxt_drain_cnt = r_drain_cnt + 16'd1;
          end
        end
      end
      S_GUARD: begin
        if (w_sel_valid) w_nxt_pending = w_sel;
        if (r_guard_cnt == LP_GUARD_LAST) begin
          w_nxt_active = w_nxt_pending;
          w_nxt_state  = S_SWITCH;
        end else begin
          w_nxt_guard_cnt = r_guard_cnt + 8'd1;
        end
      end
      S_SWITCH: begin
        w_nxt_state = S_RUN;
      end
      default: w_nxt_state = S_RUN;
    endcase
  end

  // Outputs are loaded from the next state, so each one lines up with the
  // state it describes. The new source appears together with sw_done.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_active      <= '0;
      r_pending     <= '0;
      r_drain_cnt   <= '0;
      r_guard_cnt   <= '0;
      r_ctrl_out    <= SAFE_VAL;
      r_switching   <= 1'b0;
      r_sw_done     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_active      <= w_nxt_active;
      r_pending     <= w_nxt_pending;
      r_drain_cnt   <= w_nxt_drain_cnt;
      r_guard_cnt   <= w_nxt_guard_cnt;
      r_ctrl_out    <= (w_nxt_state == S_GUARD) ? SAFE_VAL : w_src[w_nxt_active];
      r_switching   <= (w_nxt_state == S_DRAIN) || (w_nxt_state == S_GUARD);
      r_sw_done     <= (w_nxt_state == S_SWITCH);
      r_timeout_err <= w_timeout;
    end
  end

  assign ctrl_out    = r_ctrl_out;
  assign active_sel  = r_active;
  assign switching   = r_switching;
  assign sw_done     = r_sw_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_seq_ctrl_switch.sv
module tb_seq_ctrl_switch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Instance A: defaults (2 sources, DRAIN_MAX=1023, GUARD_CYC=4)
  logic        sel_a;
  logic [15:0] src_a;
  logic [1:0]  busy_a;
  logic [7:0]  ctrl_a;
  logic        act_a, sw_a, done_a, to_a;

  seq_ctrl_switch dut_a (
    .clk_sys(clk), .rst_n(rst_n), .sel(sel_a), .src_ctrl(src_a), .src_busy(busy_a),
    .ctrl_out(ctrl_a), .active_sel(act_a), .switching(sw_a), .sw_done(done_a),
    .timeout_err(to_a)
  );

  // Instance B: 4 sources, short drain timeout
  logic [1:0]  sel_b;
  logic [31:0] src_b;
  logic [3:0]  busy_b;
  logic [7:0]  ctrl_b;
  logic [1:0]  act_b;
  logic        sw_b, done_b, to_b;

  seq_ctrl_switch #(.NUM_SRC(4), .SEL_W(2), .DRAIN_MAX(16)) dut_b (
    .clk_sys(clk), .rst_n(rst_n), .sel(sel_b), .src_ctrl(src_b), .src_busy(busy_b),
    .ctrl_out(ctrl_b), .active_sel(act_b), .switching(sw_b), .sw_done(done_b),
    .timeout_err(to_b)
  );

  // Instance C: 3 sources, so sel=3 is out of range
  logic [1:0]  sel_c;
  logic [23:0] src_c;
  logic [2:0]  busy_c;
  logic [7:0]  ctrl_c;
  logic [1:0]  act_c;
  logic        sw_c, done_c, to_c;

  seq_ctrl_switch #(.NUM_SRC(3), .SEL_W(2)) dut_c (
    .clk_sys(clk), .rst_n(rst_n), .sel(sel_c), .src_ctrl(src_c), .src_busy(busy_c),
    .ctrl_out(ctrl_c), .active_sel(act_c), .switching(sw_c), .sw_done(done_c),
    .timeout_err(to_c)
  );

  typedef struct {
    logic       sel;
    logic [1:0] busy;
    logic [7:0] s0, s1;
    logic [7:0] e_ctrl;
    logic       e_act, e_sw, e_done, e_to;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ec, input logic ea,
                       input logic es, input logic ed, input logic et);
    cmp(tag, "ctrl",  {24'd0, ctrl_a}, {24'd0, ec});
    cmp(tag, "act",   {31'd0, act_a},  {31'd0, ea});
    cmp(tag, "sw",    {31'd0, sw_a},   {31'd0, es});
    cmp(tag, "done",  {31'd0, done_a}, {31'd0, ed});
    cmp(tag, "tout",  {31'd0, to_a},   {31'd0, et});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] ec, input logic [1:0] ea,
                       input logic es, input logic ed, input logic et);
    cmp(tag, "ctrl",  {24'd0, ctrl_b}, {24'd0, ec});
    cmp(tag, "act",   {30'd0, act_b},  {30'd0, ea});
    cmp(tag, "sw",    {31'd0, sw_b},   {31'd0, es});
    cmp(tag, "done",  {31'd0, done_b}, {31'd0, ed});
    cmp(tag, "tout",  {31'd0, to_b},   {31'd0, et});
  endtask

  task automatic chk_c(input string tag, input logic [7:0] ec, input logic [1:0] ea,
                       input logic es, input logic ed);
    cmp(tag, "ctrl",  {24'd0, ctrl_c}, {24'd0, ec});
    cmp(tag, "act",   {30'd0, act_c},  {30'd0, ea});
    cmp(tag, "sw",    {31'd0, sw_c},   {31'd0, es});
    cmp(tag, "done",  {31'd0, done_c}, {31'd0, ed});
  endtask

  // Drain from 'from' to 'to' with busy[from] held high. The drain lasts 16
  // cycles. The guard follows for 4 cycles, then comes the switch. If 'fall'
  // is set, busy drops exactly on the last drain cycle, so no timeout occurs.
  task automatic run_timeout(input string tag, input logic [1:0] from, input logic [1:0] to,
                             input logic [7:0] cf, input logic [7:0] ct, input bit fall);
    for (int k = 0; k <= 21; k++) begin
      sel_b  = to;
      busy_b = (fall && k >= 16) ? 4'd0 : (4'd1 << from);
      tick();
      chk_b(tag, (k < 16) ? cf : ((k < 20) ? 8'h00 : ct), (k < 20) ? from : to,
            k < 20, k == 20, !fall && k == 16);
    end
  endtask

  initial begin
    sel_a = 1'b0; src_a = {8'h3C, 8'hA5}; busy_a = 2'b00;
    sel_b = 2'd0; src_b = {8'h44, 8'h33, 8'h22, 8'h11}; busy_b = 4'd0;
    sel_c = 2'd0; src_c = {8'hC3, 8'hC2, 8'hC1}; busy_c = 3'd0;

    //            sel busy  s0     s1     ctrl   act sw done to
    tbl[0] = '{1'b0, 2'b00, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}; // run
    tbl[1] = '{1'b1, 2'b00, 8'h5A, 8'h3C, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0}; // drain (1 cycle)
    tbl[2] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // guard 1
    tbl[3] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // guard 2
    tbl[4] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // guard 3
    tbl[5] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // guard 4
    tbl[6] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0}; // switch
    tbl[7] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0}; // run on src1

    // Reset state
    tick();
    tick();
    chk_a("reset_a", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("reset_b", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Release, then idle switch 0 -> 1
    for (int i = 0; i < 8; i++) begin
      sel_a  = tbl[i].sel;
      busy_a = tbl[i].busy;
      src_a  = {tbl[i].s1, tbl[i].s0};
      tick();
      chk_a($sformatf("vec%0d", i), tbl[i].e_ctrl, tbl[i].e_act, tbl[i].e_sw,
            tbl[i].e_done, tbl[i].e_to);
    end

    // Asynchronous reset in the middle of the guard interval (1 -> 0)
    sel_a = 1'b0; busy_a = 2'b00; src_a = {8'h3C, 8'hA5};
    tick();
    chk_a("drain_1to0", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_a("guard_pre_rst", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("post_rst", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Busy drain 0 -> 1: src0 busy for 20 cycles, ctrl_out tracks it
    for (int k = 0; k <= 25; k++) begin
      sel_a  = 1'b1;
      busy_a = (k < 20) ? 2'b01 : 2'b00;
      src_a  = {8'h3C, 8'(8'h40 + k)};
      tick();
      chk_a("busy_drain", (k < 20) ? 8'(8'h40 + k) : ((k < 24) ? 8'h00 : 8'h3C),
            k >= 24, k < 24, k == 24, 1'b0);
    end

    // Abort: 0 -> 2 then back to 0 while source 0 is still busy
    sel_b = 2'd2; busy_b = 4'b0001;
    tick();
    chk_b("abort_drain", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("abort_drain2", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);
    sel_b = 2'd0;
    tick();
    chk_b("abort_run", 8'h11, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_b("abort_stay", 8'h11, 2'd0, 1'b0, 1'b0, 1'b0);

    // Retarget 0 -> 1 -> 3 across drain and guard
    sel_b = 2'd1;
    tick();
    chk_b("retgt_drain", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);
    sel_b = 2'd3;
    tick();
    chk_b("retgt_drain2", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);
    busy_b = 4'd0;
    tick();
    chk_b("retgt_guard", 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    sel_b = 2'd1;
    tick();
    sel_b = 2'd3;
    tick();
    tick();
    chk_b("retgt_guard4", 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("retgt_switch", 8'h44, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_b("retgt_run", 8'h44, 2'd3, 1'b0, 1'b0, 1'b0);

    // Drain timeout (3 -> 1), then busy-fall coinciding with timeout (1 -> 0)
    run_timeout("timeout", 2'd3, 2'd1, 8'h44, 8'h22, 1'b0);
    run_timeout("busy_wins", 2'd1, 2'd0, 8'h22, 8'h11, 1'b1);

    // Out-of-range select is ignored; a valid one then switches normally
    sel_c = 2'd3;
    tick();
    tick();
    tick();
    chk_c("invalid_sel", 8'hC1, 2'd0, 1'b0, 1'b0);
    sel_c = 2'd2;
    tick();
    chk_c("valid_drain", 8'hC1, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk_c("valid_guard", 8'h00, 2'd0, 1'b1, 1'b0);
    tick();
    chk_c("valid_switch", 8'hC3, 2'd2, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_ctrl_switch.md
Name: seq_ctrl_switch

Overview:
- Parametrised registered switch routing one of NUM_SRC pulse-sequence controller buses (CTRL_W control lines each: pulse start, dump start, phase, reset, dump-off, test, turn delay, ...) to the bridge/dump driver stage.
- Unlike a plain select-and-register mux, it never switches mid-sequence. It waits for the active source to go idle (bounded by a timeout), then forces all outputs to a safe value for a guard interval before handing over.

Parameters:
- NUM_SRC, 2, number of source controllers (2..16)
- SEL_W, 1, select width; must satisfy 2^SEL_W >= NUM_SRC
- CTRL_W, 8, control lines per source
- SAFE_VAL, {CTRL_W{1'b0}}, value driven during reset and guard
- GUARD_CYC, 4, guard length in clk_sys cycles (1..255)
- DRAIN_MAX, 1023, maximum drain wait in cycles before forced switch (1..65535)

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset: asynchronous assert, active-low
- sel  in  SEL_W  requested source index
- src_ctrl  in  NUM_SRC*CTRL_W  packed source buses; source i occupies bits [i*CTRL_W +: CTRL_W]
- src_busy  in  NUM_SRC  source i mid-sequence when 1
- ctrl_out  out  CTRL_W  registered control bus to driver stage
- active_sel  out  SEL_W  index currently routed
- switching  out  1  high in DRAIN and GUARD
- sw_done  out  1  one-cycle pulse when handover completes
- timeout_err  out  1  one-cycle pulse when drain times out

Behaviour:
- Reset (async, rst_n=0): state=RUN, active_sel=0, pending=0, ctrl_out=SAFE_VAL, switching=0, sw_done=0, timeout_err=0, counters=0.
- Invalid select: sel >= NUM_SRC is treated as equal to active_sel, so no switch starts.
- RUN:
  - ctrl_out <= src_ctrl[active_sel] every cycle, giving 1-cycle latency.
  - If sel is valid and differs from active_sel: pending <= sel, drain counter <= 0, go to DRAIN.
- DRAIN:
  - switching=1; ctrl_out keeps following the active source.
  - If src_busy[active_sel]==0: go to GUARD with guard counter <= 0. This is checked on entry, so an idle source spends exactly 1 cycle in DRAIN.
  - Else if drain counter == DRAIN_MAX-1: pulse timeout_err, go to GUARD.
  - Else increment the drain counter.
  - If sel returns to active_sel (or becomes invalid): abort to RUN. No sw_done, no guard.
  - If sel moves to a third valid index: pending <= sel; the drain counter is not restarted.
- GUARD:
  - ctrl_out <= SAFE_VAL for exactly GUARD_CYC cycles; switching=1.
  - Valid sel changes update pending; abort is not possible.
  - On the last guard cycle, go to SWITCH.
- SWITCH (1 cycle):
  - active_sel <= pending, sw_done=1, switching=0.
  - ctrl_out <= src_ctrl[pending], so the new source appears on ctrl_out in the SWITCH cycle.
  - Next state is RUN. If sel already differs from the new active_sel, DRAIN starts the following cycle.
- Simultaneous events: a busy-fall and timeout in the same cycle → busy wins, no timeout_err.
- Reset during any state: immediate return to reset values. No guard is applied; ctrl_out is already SAFE_VAL.
- Output hygiene: all outputs registered, no combinational path input→output.

Optional Feature:
- Macro SEQ_SW_SYNC_SEL_EN.
- Defined: sel and src_busy each pass through a 2-flop synchroniser (reset to 0) before use, for sources in another clock domain. Every sel/busy-related latency above grows by 2 cycles.
- Undefined: sel and src_busy are used directly; they must be synchronous to clk_sys.

Test Plan:
- Reset release, NUM_SRC=2, CTRL_W=8, src0=8'hA5, sel=0 → ctrl_out=8'h00 during reset, 8'hA5 one cycle after release; active_sel=0.
- Idle switch: src_busy=0, sel 0→1, src1=8'h3C, GUARD_CYC=4 → 1 DRAIN cycle at src0 data, 4 cycles 8'h00, sw_done pulse with ctrl_out=8'h3C, active_sel=1.
- Busy drain: src_busy[0]=1 for 20 cycles after sel→1 → ctrl_out tracks src0 for 20 cycles, then guard, then switch; timeout_err=0.
- Timeout: DRAIN_MAX=16, src_busy[0] stuck 1 → timeout_err pulse 16 cycles after DRAIN entry, guard, switch to 1.
- Abort and retarget: NUM_SRC=4; sel 0→2, back to 0 within drain → RUN, no sw_done. Then sel 0→1→3 during drain/guard → final active_sel=3. sel=3 with NUM_SRC=3 → ignored.
- Async reset asserted mid-GUARD → outputs reset without a clock edge; state RUN, active_sel=0.
